// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and constants for the framed SIPO receiver
// SIPO_PARITY_EN adds the PARITY state to the state enum.
package sipo_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam logic IDLE_LEVEL = 1'b1;
   localparam logic STOP_LEVEL = 1'b1;

`ifdef SIPO_PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_STOP = 2'd3
   } state_t;
`endif

endpackage

// File: rtl/sipo_shift.sv
// rtl/sipo_shift.sv - serial-in/parallel-out shift register, LSB-first fill
module sipo_shift
   import sipo_pkg::*;
#(
   parameter int W = DEFAULT_DATA_W
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         shift_en,
   input  logic         din,
   output logic [W-1:0] q
);

   // New bits enter at the MSB so the first bit received ends up at bit 0.
   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (shift_en) begin
         q <= {din, q[W-1:1]};
      end
   end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - start/data/stop framed serial receiver with valid/ready output
// Optional SIPO_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module sipo_frame_ctrl
   import sipo_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              serial_in,
   input  logic              frame_en,
   input  logic              data_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun
);

   localparam int CNT_W = $clog2(DATA_W);

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              shift_en;
   logic              last_bit;
   logic              par_ok;
   logic              good_frame;
   logic [DATA_W-1:0] shift_q;

   sipo_shift #(.W(DATA_W)) u_shift (
      .clk      (clk),
      .clr      (rst),
      .shift_en (shift_en),
      .din      (serial_in),
      .q        (shift_q)
   );

   assign last_bit   = (cnt_q == CNT_W'(DATA_W - 1));
   assign busy       = (state_q != ST_IDLE);
   assign good_frame = (serial_in == STOP_LEVEL) && par_ok;

   always_comb begin
      state_d  = state_q;
      shift_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (frame_en && (serial_in != IDLE_LEVEL)) state_d = ST_DATA;
         end
         ST_DATA: begin
            shift_en = 1'b1;
`ifdef SIPO_PARITY_EN
            if (last_bit) state_d = ST_PARITY;
`else
            if (last_bit) state_d = ST_STOP;
`endif
         end
`ifdef SIPO_PARITY_EN
         ST_PARITY: state_d = ST_STOP;
`endif
         ST_STOP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef SIPO_PARITY_EN
   // Data bits plus the parity bit must hold an even number of ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_ok <= 1'b1;
      end else if (state_q == ST_PARITY) begin
         par_ok <= ~(^{shift_q, serial_in});
      end
   end
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (state_q == ST_DATA) begin
            cnt_q <= last_bit ? '0 : cnt_q + CNT_W'(1);
         end
         if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
         // A completed frame may reload in the same edge the consumer takes the old word.
         if (state_q == ST_STOP) begin
            if (!good_frame) begin
               frame_err <= 1'b1;
            end else if (!data_valid || data_ready) begin
               data_out   <= shift_q;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb/tb_sipo_frame_ctrl.sv - self-checking bench for sipo_frame_ctrl (honours SIPO_PARITY_EN)
module tb_sipo_frame_ctrl;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              serial_in;
   logic              frame_en;
   logic              data_ready;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              busy;
   logic              frame_err;
   logic              overrun;

   int checks = 0;
   int errors = 0;

   // Transaction-level expectation of the receiver's visible outputs.
   logic [DATA_W-1:0] m_data = '0;
   bit                m_valid = 1'b0;
   bit                m_ferr = 1'b0;
   bit                m_ovr = 1'b0;
   bit                m_busy = 1'b0;
   logic [DATA_W-1:0] cur_payload = '0;

   always #5 clk = ~clk;

   sipo_frame_ctrl #(.DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .serial_in  (serial_in),
      .frame_en   (frame_en),
      .data_ready (data_ready),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("data_out",   32'(data_out),   32'(m_data));
      check("data_valid", 32'(data_valid), 32'(m_valid));
      check("frame_err",  32'(frame_err),  32'(m_ferr));
      check("overrun",    32'(overrun),    32'(m_ovr));
      check("busy",       32'(busy),       32'(m_busy));
   endtask

   function automatic bit rdy_val(input int mode);
      if (mode == 2) return bit'($urandom_range(0, 1));
      return (mode == 1);
   endfunction

   // One clock: drive inputs, take the edge, update the model, check away from the edge.
   task automatic cycle(input bit sin, input bit rdy, input bit fen,
                        input bit last, input bit good, input bit busy_after);
      bit old_valid;
      serial_in  = sin;
      data_ready = rdy;
      frame_en   = fen;
      @(posedge clk);
      old_valid = m_valid;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (old_valid && rdy) m_valid = 1'b0;
      if (last) begin
         if (!good) begin
            m_ferr = 1'b1;
         end else if (!old_valid || rdy) begin
            m_valid = 1'b1;
            m_data  = cur_payload;
         end else begin
            m_ovr = 1'b1;
         end
      end
      m_busy = busy_after;
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      serial_in  = 1'b1;
      frame_en   = 1'b1;
      data_ready = 1'b0;
      @(posedge clk);
      m_data  = '0;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      m_busy  = 1'b0;
      #1;
      check_all();
      rst = 1'b0;
   endtask

   task automatic idle(input int n, input int rdy_mode, input bit fen_rand);
      bit fen;
      for (int i = 0; i < n; i++) begin
         fen = fen_rand ? bit'($urandom_range(0, 1)) : 1'b1;
         cycle(fen ? 1'b1 : bit'($urandom_range(0, 1)), rdy_val(rdy_mode), fen, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // fen_drop lowers frame_en from cycle 3 of the frame onward.
   task automatic send_frame(input logic [DATA_W-1:0] p, input bit stop_b, input bit par_b,
                             input int rdy_mode, input bit fen_drop);
      bit good;
      cur_payload = p;
      good = stop_b;
`ifdef SIPO_PARITY_EN
      good = good && ((^p ^ par_b) == 1'b0);
`endif
      cycle(1'b0, rdy_val(rdy_mode), 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < DATA_W; i++) begin
         cycle(p[i], rdy_val(rdy_mode), fen_drop ? (i < 2) : bit'($urandom_range(0, 1)),
               1'b0, 1'b0, 1'b1);
      end
`ifdef SIPO_PARITY_EN
      cycle(par_b, rdy_val(rdy_mode), 1'b1, 1'b0, 1'b0, 1'b1);
`endif
      cycle(stop_b, rdy_val(rdy_mode), fen_drop ? 1'b0 : 1'b1, 1'b1, good, 1'b0);
   endtask

   initial begin
      logic [DATA_W-1:0] p;
      logic [DATA_W-1:0] part;
      bit                stop_b;
      bit                par_b;

      do_reset();
      idle(2, 1, 1'b0);

      // Bad stop bit on a fresh receiver: error pulse only, outputs untouched.
      send_frame(8'h3C, 1'b0, ^8'h3C, 1, 1'b0);
      idle(2, 1, 1'b0);

      // Good frame with ready high: valid for one cycle.
      send_frame(8'hA5, 1'b1, ^8'hA5, 1, 1'b0);
      idle(2, 1, 1'b0);

      // Held word blocks a back-to-back frame, then is consumed.
      send_frame(8'h11, 1'b1, ^8'h11, 0, 1'b0);
      send_frame(8'h22, 1'b1, ^8'h22, 0, 1'b0);
      idle(2, 0, 1'b0);
      idle(2, 1, 1'b0);

      // Reset in cycle 4 of a frame, then a clean frame.
      part = 8'h55;
      cur_payload = part;
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(part[i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      do_reset();
      idle(DATA_W + 3, 1, 1'b0);
      send_frame(8'h0F, 1'b1, ^8'h0F, 1, 1'b0);
      idle(1, 1, 1'b0);

      // Start bits ignored while frame_en is low; frame_en dropping mid-frame is harmless.
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b1, ^8'hC3, 1, 1'b1);
      idle(1, 1, 1'b0);

`ifdef SIPO_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 1, 1'b0);
      idle(2, 1, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0, 1, 1'b0);
      idle(2, 1, 1'b0);
`endif

      // Randomized traffic: payloads, bad stop/parity, ready, gaps, frame_en noise.
      for (int f = 0; f < 60; f++) begin
         p      = DATA_W'($urandom);
         stop_b = ($urandom_range(0, 3) != 0);
         par_b  = ($urandom_range(0, 3) != 0) ? ^p : ~(^p);
         send_frame(p, stop_b, par_b, 2, 1'b0);
         idle($urandom_range(0, 3), 2, 1'b1);
      end
      idle(3, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 Parameter: DATA_W, default 8, serial payload bits per frame (range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: serial_in  input  1  serial line, idle high, one bit sampled per clk.
REQ-005 Port: frame_en  input  1  enables start-bit detection; high = receive allowed.
REQ-006 Port: data_ready  input  1  consumer accepts data_out when high with data_valid.
REQ-007 Port: data_out  output  DATA_W  last received payload, LSB = first data bit received.
REQ-008 Port: data_valid  output  1  data_out holds an unconsumed word.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: frame_err  output  1  one-cycle pulse: bad stop bit (or bad parity, REQ-027).
REQ-011 Port: overrun  output  1  one-cycle pulse: good frame dropped because the held word was not consumed.

Function
REQ-012 FSM states SHALL be IDLE, DATA, PARITY (macro only), STOP.
REQ-013 IDLE: serial_in==0 and frame_en==1 sampled -> DATA; start cycle = cycle 0.
REQ-014 DATA: one bit is shifted per cycle for DATA_W cycles (cycles 1..DATA_W), LSB first; the bit counter wraps to 0 on leaving DATA.
REQ-015 After the last data bit -> STOP (or PARITY with macro); STOP lasts one cycle, then -> IDLE unconditionally.
REQ-016 STOP with serial_in==1 is a good frame; serial_in==0 pulses frame_err in the following cycle, discards the payload, and leaves data_out/data_valid unchanged.
REQ-017 Good frame with data_valid==0, or data_valid==1 and data_ready==1 in the STOP cycle: data_out is loaded and data_valid==1 from cycle DATA_W+2.
REQ-018 Good frame with data_valid==1 and data_ready==0 in the STOP cycle: overrun pulses for one cycle; the frame is dropped; data_out is unchanged.
REQ-019 data_valid falls in the cycle after data_ready==1 is sampled with data_valid==1, unless REQ-017 reloads it in that same edge.
REQ-020 data_out SHALL stay stable while data_valid==1.
REQ-021 frame_en gates only start detection; deasserting it mid-frame does not abort the frame.
REQ-022 Back-to-back: a start bit in the first IDLE cycle after STOP is accepted (minimum frame period DATA_W+2 cycles).
REQ-023 data_ready while data_valid==0 SHALL be ignored.

Reset
REQ-024 rst==1 at an edge forces IDLE, bit counter 0, shift register 0, data_out 0, data_valid 0, busy 0, frame_err 0, overrun 0.
REQ-025 Reset mid-frame abandons the frame silently, with no pulse on frame_err or overrun; reception restarts at the next start bit after rst falls.

Configuration
REQ-026 Macro SIPO_PARITY_EN undefined: frame = start + DATA_W + stop; the PARITY state is absent.
REQ-027 Macro SIPO_PARITY_EN defined: a one-cycle PARITY state follows DATA; the sampled bit must make the data bits plus parity an even count of ones. On mismatch, frame_err pulses after STOP and the frame is discarded as in REQ-016; frame period = DATA_W+3.

Structure
REQ-028 Package sipo_pkg SHALL hold the FSM state enum typedef, the default DATA_W constant, and the IDLE_LEVEL/STOP_LEVEL constants.
REQ-029 Sub-module sipo_shift SHALL hold the DATA_W-bit serial-in/parallel-out shift register with shift-enable and sync clear; sipo_frame_ctrl holds the FSM, counter, output register and handshake.

Verification
REQ-030 DATA_W=8, frame_en=1, ready=1: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> data_out=8'hA5, data_valid high at cycle 10, falls at cycle 11.
REQ-031 Stop bit=0 for payload 0x3C -> frame_err high for exactly one cycle at cycle 10; data_valid stays 0; data_out stays 0.
REQ-032 ready=0: send 0x11, then 0x22 back-to-back -> overrun pulses once after the second stop; data_out stays 8'h11; raising ready drops data_valid next cycle.
REQ-033 rst=1 at cycle 4 of a frame -> all outputs 0 next cycle and no pulses; then 0x0F sent -> data_out=8'h0F.
REQ-034 frame_en=0 with a start bit -> busy stays 0; frame_en falling at cycle 3 of a frame -> frame still completes.
REQ-035 SIPO_PARITY_EN defined: 0x07 with parity=1 -> valid at cycle 11; with parity=0 -> frame_err pulse, no data_valid.
